// File: rtl/pe_pkg.sv
// Shared PE definitions: loader FSM state encoding and default datapath/scratchpad sizes.
package pe_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        LOAD_FILTER = 2'd1,
        LOAD_IFMAP  = 2'd2,
        READY       = 2'd3
    } loader_state_t;

    localparam int unsigned PeWidth     = 4;
    localparam int unsigned PeSizeIfmap = 4;
    localparam int unsigned PeSizeSram  = 4;

endpackage

// File: rtl/pe_spad_write_port.sv
// One scratchpad write port: address counter plus a registered wen/addr/din stage.
// A fire in cycle t produces the write on the port in cycle t+1.
module pe_spad_write_port #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned SIZE       = 4,
    parameter int unsigned ADDR_WIDTH = $clog2(SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  fire,
    input  logic [WIDTH-1:0]      data,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [WIDTH-1:0]      din,
    output logic                  last
);

    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(SIZE - 1);

    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]      din_q, din_d;

    always_comb begin
        cnt_d  = cnt_q;
        wen_d  = fire;
        addr_d = addr_q;
        din_d  = din_q;
        if (fire) begin
            addr_d = cnt_q;
            din_d  = data;
        end
        // Clear wins over increment so the final word of a phase leaves the counter at 0.
        if (clear) begin
            cnt_d = '0;
        end else if (fire && (cnt_q != LastAddr)) begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            wen_q  <= 1'b0;
            addr_q <= '0;
            din_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            wen_q  <= wen_d;
            addr_q <= addr_d;
            din_q  <= din_d;
        end
    end

    assign wen  = wen_q;
    assign addr = addr_q;
    assign din  = din_q;
    assign last = (cnt_q == LastAddr);

endmodule

// File: rtl/pe_spad_loader.sv
// Write-side feeder for a PE's filter SRAM and ifmap RF from a valid/ready word stream.
// Optional PE_LOADER_KEEP_FILTER_EN adds keep_filter so start can skip the filter load.
module pe_spad_loader
    import pe_pkg::*;
#(
    parameter int unsigned WIDTH             = PeWidth,
    parameter int unsigned SIZE_IFMAP        = PeSizeIfmap,
    parameter int unsigned ADDR_WIDTH_IFMAP  = $clog2(SIZE_IFMAP),
    parameter int unsigned SIZE_SRAM         = PeSizeSram,
    parameter int unsigned ADDR_WIDTH_FILTER = $clog2(SIZE_SRAM)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         ifmap_release,
`ifdef PE_LOADER_KEEP_FILTER_EN
    input  logic                         keep_filter,
`endif
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         in_ready,
    output logic                         filter_wen,
    output logic [ADDR_WIDTH_FILTER-1:0] filter_w_addr,
    output logic [WIDTH-1:0]             filter_din,
    output logic                         ifmap_wen,
    output logic [ADDR_WIDTH_IFMAP-1:0]  ifmap_w_addr,
    output logic [WIDTH-1:0]             ifmap_din,
    output logic                         loaded,
    output logic                         busy
);

    loader_state_t state_q, state_d;
    loader_state_t entry_state;
    logic          loaded_q, loaded_d;
    logic          skip_filter;
    logic          handshake;
    logic          filter_fire, ifmap_fire;
    logic          filter_clear, ifmap_clear;
    logic          filter_last, ifmap_last;

`ifdef PE_LOADER_KEEP_FILTER_EN
    assign skip_filter = keep_filter;
`else
    assign skip_filter = 1'b0;
`endif

    assign entry_state = skip_filter ? LOAD_IFMAP : LOAD_FILTER;
    assign busy        = (state_q == LOAD_FILTER) || (state_q == LOAD_IFMAP);
    assign in_ready    = busy;
    assign handshake   = in_valid && in_ready;
    assign filter_fire = handshake && (state_q == LOAD_FILTER);
    assign ifmap_fire  = handshake && (state_q == LOAD_IFMAP);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = entry_state;
                end
            end
            LOAD_FILTER: begin
                if (filter_fire && filter_last) begin
                    state_d = LOAD_IFMAP;
                end
            end
            LOAD_IFMAP: begin
                if (ifmap_fire && ifmap_last) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (start) begin
                    state_d = entry_state;
                end else if (ifmap_release) begin
                    state_d = LOAD_IFMAP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Counters restart on every phase entry and exit.
    assign filter_clear = (state_d != state_q) &&
                          ((state_d == LOAD_FILTER) || (state_q == LOAD_FILTER));
    assign ifmap_clear  = (state_d != state_q) &&
                          ((state_d == LOAD_IFMAP) || (state_q == LOAD_IFMAP));

    // Staying in READY for a second cycle means the last write has landed in the pad.
    assign loaded_d = (state_q == READY) && (state_d == READY);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            loaded_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            loaded_q <= loaded_d;
        end
    end

    assign loaded = loaded_q;

    pe_spad_write_port #(
        .WIDTH      (WIDTH),
        .SIZE       (SIZE_SRAM),
        .ADDR_WIDTH (ADDR_WIDTH_FILTER)
    ) u_filter_port (
        .clk   (clk),
        .rst   (rst),
        .clear (filter_clear),
        .fire  (filter_fire),
        .data  (in_data),
        .wen   (filter_wen),
        .addr  (filter_w_addr),
        .din   (filter_din),
        .last  (filter_last)
    );

    pe_spad_write_port #(
        .WIDTH      (WIDTH),
        .SIZE       (SIZE_IFMAP),
        .ADDR_WIDTH (ADDR_WIDTH_IFMAP)
    ) u_ifmap_port (
        .clk   (clk),
        .rst   (rst),
        .clear (ifmap_clear),
        .fire  (ifmap_fire),
        .data  (in_data),
        .wen   (ifmap_wen),
        .addr  (ifmap_w_addr),
        .din   (ifmap_din),
        .last  (ifmap_last)
    );

`ifndef SYNTHESIS
    wen_exclusive_a: assert property (@(posedge clk) disable iff (rst)
        !(filter_wen && ifmap_wen));
`endif

endmodule

// File: tb/tb_pe_spad_loader.sv
// Directed bench for pe_spad_loader: full loads, gapped streams, ifmap refill, reset abort.
module tb_pe_spad_loader;

    localparam int unsigned W   = 4;
    localparam int unsigned AWI = 2;
    localparam int unsigned AWF = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           ifmap_release;
    logic           keep_filter;
    logic           in_valid;
    logic [W-1:0]   in_data;
    logic           in_ready;
    logic           filter_wen;
    logic [AWF-1:0] filter_w_addr;
    logic [W-1:0]   filter_din;
    logic           ifmap_wen;
    logic [AWI-1:0] ifmap_w_addr;
    logic [W-1:0]   ifmap_din;
    logic           loaded;
    logic           busy;

    pe_spad_loader u_dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .ifmap_release (ifmap_release),
`ifdef PE_LOADER_KEEP_FILTER_EN
        .keep_filter   (keep_filter),
`endif
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .filter_wen    (filter_wen),
        .filter_w_addr (filter_w_addr),
        .filter_din    (filter_din),
        .ifmap_wen     (ifmap_wen),
        .ifmap_w_addr  (ifmap_w_addr),
        .ifmap_din     (ifmap_din),
        .loaded        (loaded),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    wr_t  fq[$];
    wr_t  iq[$];
    int   rq[$];
    int   cyc = 0;
    int   overlap = 0;
    logic loaded_prev = 1'b0;
    int   last_hs = -1;
    int   first_hs = -1;
    int   errs = 0;
    int   checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed writes and loaded rising edges, tagged with the cycle of the preceding edge.
    always @(negedge clk) begin
        if (filter_wen) fq.push_back('{int'(filter_w_addr), int'(filter_din), cyc});
        if (ifmap_wen) iq.push_back('{int'(ifmap_w_addr), int'(ifmap_din), cyc});
        if (filter_wen && ifmap_wen) overlap <= overlap + 1;
        if (loaded && !loaded_prev) rq.push_back(cyc);
        loaded_prev <= loaded;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] w);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        if (n == 20) check_eq("in_ready_wait", 32'(in_ready), 1);
        step();
        last_hs  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic check_writes(input string tag, input bit filt, input int base, input int n,
                                input int data0);
        wr_t e;
        int  sz;
        sz = filt ? fq.size() : iq.size();
        check_eq({tag, "_count"}, sz - base, n);
        for (int i = 0; i < n; i++) begin
            if (base + i < sz) begin
                if (filt) e = fq[base + i];
                else      e = iq[base + i];
                check_eq($sformatf("%s_addr%0d", tag, i), e.addr, i);
                check_eq($sformatf("%s_data%0d", tag, i), e.data, data0 + i);
            end
        end
    endtask

    task automatic check_loaded(input string tag, input int rb);
        check_eq({tag, "_rise_n"}, rq.size() - rb, 1);
        if (rq.size() > rb) check_eq({tag, "_rise_cyc"}, rq[rb], last_hs + 1);
        check_eq({tag, "_loaded"}, 32'(loaded), 1);
        check_eq({tag, "_busy"}, 32'(busy), 0);
    endtask

    int fb, ib, rb;

    initial begin
        rst = 1'b1; start = 1'b0; ifmap_release = 1'b0; keep_filter = 1'b0;
        in_valid = 1'b0; in_data = '0;
        step();
        step();
        check_eq("rst_ctrl", {in_ready, busy, filter_wen, ifmap_wen, loaded}, 0);
        check_eq("rst_data", {filter_w_addr, filter_din, ifmap_w_addr, ifmap_din}, 0);
        rst = 1'b0;

        // IDLE: stream and release are ignored
        in_valid = 1'b1; in_data = 4'd7; ifmap_release = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            ifmap_release = 1'b0;
            check_eq("idle_ready", 32'(in_ready), 0);
            check_eq("idle_busy", 32'(busy), 0);
        end
        in_valid = 1'b0;
        step();
        check_eq("idle_writes", fq.size() + iq.size(), 0);

        // Full load, in_valid held high
        fb = fq.size(); ib = iq.size(); rb = rq.size();
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("t1_busy", 32'(busy), 1);
        for (int k = 1; k <= 8; k++) begin
            send(4'(k));
            if (k == 1) first_hs = last_hs;
        end
        step(); step(); step();
        check_writes("t1_f", 1'b1, fb, 4, 1);
        check_writes("t1_i", 1'b0, ib, 4, 5);
        if (fq.size() >= fb + 4 && iq.size() >= ib + 4) begin
            check_eq("t1_f0_cyc", fq[fb].cyc, first_hs);
            check_eq("t1_f3_cyc", fq[fb + 3].cyc, first_hs + 3);
            check_eq("t1_i0_cyc", iq[ib].cyc, first_hs + 4);
            check_eq("t1_i3_cyc", iq[ib + 3].cyc, last_hs);
        end
        check_loaded("t1", rb);

        // Gapped stream; start and release while busy must be ignored
        fb = fq.size(); ib = iq.size(); rb = rq.size();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            send(4'(k + 3));
            if (k == 1) start = 1'b1;
            if (k == 5) ifmap_release = 1'b1;
            step();
            start = 1'b0; ifmap_release = 1'b0;
        end
        step(); step();
        check_writes("t2_f", 1'b1, fb, 4, 3);
        check_writes("t2_i", 1'b0, ib, 4, 7);
        if (fq.size() >= fb + 2) check_eq("t2_gap", fq[fb + 1].cyc - fq[fb].cyc, 2);
        check_loaded("t2", rb);

        // Release: ifmap-only refill
        fb = fq.size(); ib = iq.size(); rb = rq.size();
        ifmap_release = 1'b1;
        step();
        ifmap_release = 1'b0;
        check_eq("t3_loaded_drop", 32'(loaded), 0);
        check_eq("t3_busy", 32'(busy), 1);
        for (int k = 0; k < 4; k++) send(4'(k + 9));
        step(); step(); step();
        check_writes("t3_i", 1'b0, ib, 4, 9);
        check_eq("t3_no_filter", fq.size() - fb, 0);
        check_loaded("t3", rb);

        // start and release together: start wins, then reset after two filter words
        fb = fq.size(); ib = iq.size();
        start = 1'b1; ifmap_release = 1'b1;
        step();
        start = 1'b0; ifmap_release = 1'b0;
        send(4'd5);
        send(4'd6);
        step();
        check_writes("t4_f", 1'b1, fb, 2, 5);
        check_eq("t4_no_ifmap", iq.size() - ib, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("t5_rst_ctrl", {in_ready, busy, filter_wen, ifmap_wen, loaded}, 0);
        check_eq("t5_rst_data", {filter_w_addr, filter_din, ifmap_w_addr, ifmap_din}, 0);
        step();
        check_eq("t5_idle_busy", 32'(busy), 0);

        fb = fq.size(); ib = iq.size(); rb = rq.size();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 8; k++) send(4'(k + 2));
        step(); step(); step();
        check_writes("t5_f", 1'b1, fb, 4, 2);
        check_writes("t5_i", 1'b0, ib, 4, 6);
        check_loaded("t5", rb);

        // READY: in_valid without start is not consumed
        fb = fq.size(); ib = iq.size(); rb = rq.size();
        in_valid = 1'b1; in_data = 4'hF;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("t6_ready", 32'(in_ready), 0);
            check_eq("t6_loaded", 32'(loaded), 1);
        end
        in_valid = 1'b0;
        step();
        check_eq("t6_writes", (fq.size() - fb) + (iq.size() - ib), 0);
        check_eq("t6_no_rise", rq.size() - rb, 0);

        check_eq("wen_overlap", overlap, 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
